rob_finish_arbiter: RTL and testbench

ROB_FINISH_ARBITER -- requirements
Module: rob_finish_arbiter

---
 rtl/rob_finish_arbiter_pkg.sv | 15 +
 rtl/rob_finish_arbiter_rr_pick.sv | 30 +++
 rtl/rob_finish_arbiter.sv | 108 ++++++++++
 tb/tb_rob_finish_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_finish_arbiter_pkg.sv
// Shared constants for the ROB finish-port arbiter: tag width, requester count
// and the fixed execution-unit requester indices.
package rob_finish_arbiter_pkg;

    localparam int unsigned RRF_SEL = 6;
    localparam int unsigned NREQ    = 4;

    localparam int unsigned ALU1 = 0;
    localparam int unsigned ALU2 = 1;
    localparam int unsigned MUL  = 2;
    localparam int unsigned LDST = 3;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/rob_finish_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req scanning upward from start, wrapping
// modulo NREQ. Returns a one-hot grant, its index and a found flag.
module rob_finish_arbiter_rr_pick #(
    parameter int unsigned NREQ  = rob_finish_arbiter_pkg::NREQ,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] start,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        int unsigned pos;
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        pos = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = (32'(start) + i) % NREQ;
            if (!vld && req[PTR_W'(pos)]) begin
                vld              = 1'b1;
                idx              = PTR_W'(pos);
                gnt[PTR_W'(pos)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_finish_arbiter.sv
// Shares the two ROB finish ports among the execution units with a round-robin
// pointer; grants are combinational, finish strobes and tags are registered.
module rob_finish_arbiter #(
    parameter int unsigned RRF_SEL = rob_finish_arbiter_pkg::RRF_SEL,
    parameter int unsigned NREQ    = rob_finish_arbiter_pkg::NREQ
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*RRF_SEL-1:0] req_addr_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic                    flush_i,
    output logic                    finish_0_o,
    output logic                    finish_1_o,
    output logic [RRF_SEL-1:0]      finish_0_addr_o,
    output logic [RRF_SEL-1:0]      finish_1_addr_o,
    output logic [15:0]             conflict_cnt_o
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned POP_W = $clog2(NREQ + 1);
    localparam int unsigned CNT_W = rob_finish_arbiter_pkg::CNT_W;

    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic [PTR_W-1:0]   last_idx;
    logic [NREQ-1:0]    gnt0_oh;
    logic [NREQ-1:0]    gnt1_oh;
    logic [NREQ-1:0]    req1_mask;
    logic [PTR_W-1:0]   gnt0_idx;
    logic [PTR_W-1:0]   gnt1_idx;
    logic               gnt0_vld;
    logic               gnt1_vld;
    logic               arb_en;
    logic               fire0;
    logic               fire1;
    logic               conflict;
    logic [POP_W-1:0]   n_valid;
    logic [RRF_SEL-1:0] tag [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_tag
        assign tag[k] = req_addr_i[k*RRF_SEL +: RRF_SEL];
    end

    rob_finish_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick0 (
        .req   (req_valid_i),
        .start (rr_ptr_q),
        .gnt   (gnt0_oh),
        .idx   (gnt0_idx),
        .vld   (gnt0_vld)
    );

    // Masking grant 0 and rescanning from the same pointer yields the next
    // valid requester after grant 0 in scan order.
    assign req1_mask = req_valid_i & ~gnt0_oh;

    rob_finish_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick1 (
        .req   (req1_mask),
        .start (rr_ptr_q),
        .gnt   (gnt1_oh),
        .idx   (gnt1_idx),
        .vld   (gnt1_vld)
    );

    assign arb_en      = reset & ~flush_i;
    assign fire0       = arb_en & gnt0_vld;
    assign fire1       = arb_en & gnt1_vld;
    assign req_ready_o = arb_en ? (gnt0_oh | gnt1_oh) : '0;

    // Pointer moves just past the last requester served this cycle.
    always_comb begin
        last_idx = gnt1_vld ? gnt1_idx : gnt0_idx;
        rr_ptr_d = (32'(last_idx) == NREQ - 1) ? '0 : last_idx + PTR_W'(1);
        n_valid  = POP_W'($countones(req_valid_i));
        conflict = arb_en && (n_valid > POP_W'(2));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            finish_0_o      <= 1'b0;
            finish_1_o      <= 1'b0;
            finish_0_addr_o <= '0;
            finish_1_addr_o <= '0;
            rr_ptr_q        <= '0;
            conflict_cnt_o  <= '0;
        end else begin
            finish_0_o <= fire0;
            finish_1_o <= fire1;
            if (fire0) begin
                finish_0_addr_o <= tag[gnt0_idx];
                rr_ptr_q        <= rr_ptr_d;
            end
            if (fire1) begin
                finish_1_addr_o <= tag[gnt1_idx];
            end
            if (conflict && (conflict_cnt_o != '1)) begin
                conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rob_finish_arbiter.sv
// Bench for rob_finish_arbiter: directed cases with literal expectations, then
// constrained-random traffic compared every cycle against a queue-based model.
module tb_rob_finish_arbiter;

    localparam int unsigned W = 6;
    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid_i;
    logic [N*W-1:0] req_addr_i;
    logic [N-1:0]   req_ready_o;
    logic           flush_i;
    logic           finish_0_o;
    logic           finish_1_o;
    logic [W-1:0]   finish_0_addr_o;
    logic [W-1:0]   finish_1_addr_o;
    logic [15:0]    conflict_cnt_o;

    rob_finish_arbiter #(.RRF_SEL(W), .NREQ(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid_i),
        .req_addr_i      (req_addr_i),
        .req_ready_o     (req_ready_o),
        .flush_i         (flush_i),
        .finish_0_o      (finish_0_o),
        .finish_1_o      (finish_1_o),
        .finish_0_addr_o (finish_0_addr_o),
        .finish_1_addr_o (finish_1_addr_o),
        .conflict_cnt_o  (conflict_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: list valid units in scan order from ptr, the first two win.
    function automatic void pick(input logic [3:0] v, input int ptr,
                                 output int g0, output int g1, output int n);
        int q[$];
        for (int i = 0; i < 4; i++) begin
            int u;
            u = (ptr + i) % 4;
            if (v[u]) q.push_back(u);
        end
        n  = (q.size() > 2) ? 2 : q.size();
        g0 = (n > 0) ? q[0] : 0;
        g1 = (n > 1) ? q[1] : 0;
    endfunction

    function automatic logic [W-1:0] tag_of(input logic [N*W-1:0] a, input int u);
        return a[u*W +: W];
    endfunction

    int           m_ptr = 0;
    int           m_cnt = 0;
    logic         m_f0 = 1'b0;
    logic         m_f1 = 1'b0;
    logic [W-1:0] m_a0 = '0;
    logic [W-1:0] m_a1 = '0;
    logic [3:0]   m_gnt = '0;
    int           waits [4] = '{0, 0, 0, 0};

    // Behavioural model of the registered state.
    always @(posedge clk or negedge reset) begin
        int g0, g1, n;
        if (!reset) begin
            m_ptr = 0; m_cnt = 0; m_f0 = 0; m_f1 = 0; m_a0 = '0; m_a1 = '0; m_gnt = '0;
            for (int k = 0; k < 4; k++) waits[k] = 0;
        end else begin
            pick(req_valid_i, m_ptr, g0, g1, n);
            m_gnt = '0;
            if (flush_i) begin
                m_f0 = 1'b0;
                m_f1 = 1'b0;
                for (int k = 0; k < 4; k++) waits[k] = 0;
            end else begin
                m_f0 = (n > 0);
                m_f1 = (n > 1);
                if (n > 0) begin
                    m_a0 = tag_of(req_addr_i, g0);
                    m_gnt[g0] = 1'b1;
                    m_ptr = (((n > 1) ? g1 : g0) + 1) % 4;
                end
                if (n > 1) begin
                    m_a1 = tag_of(req_addr_i, g1);
                    m_gnt[g1] = 1'b1;
                end
                if ($countones(req_valid_i) > 2 && m_cnt < 65535) m_cnt++;
                for (int k = 0; k < 4; k++) begin
                    if (req_valid_i[k] && m_gnt[k]) begin
                        total++;
                        if (waits[k] > 1) begin
                            bad++;
                            $display("FAIL fairness unit%0d: waited %0d cycles, limit 1", k, waits[k]);
                        end
                        waits[k] = 0;
                    end else if (req_valid_i[k]) begin
                        waits[k]++;
                    end else begin
                        waits[k] = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        int g0, g1, n;
        logic [3:0] exp_rdy;
        if (chk_en) begin
            exp_rdy = '0;
            pick(req_valid_i, m_ptr, g0, g1, n);
            if (reset && !flush_i) begin
                if (n > 0) exp_rdy[g0] = 1'b1;
                if (n > 1) exp_rdy[g1] = 1'b1;
            end
            check("ready", 32'(req_ready_o), 32'(exp_rdy));
            check("fin0", 32'(finish_0_o), 32'(m_f0));
            check("fin1", 32'(finish_1_o), 32'(m_f1));
            check("addr0", 32'(finish_0_addr_o), 32'(m_a0));
            check("addr1", 32'(finish_1_addr_o), 32'(m_a1));
            check("cnt", 32'(conflict_cnt_o), 32'(m_cnt));
        end
    end

    task automatic cyc(input logic [3:0] v, input logic [N*W-1:0] a, input logic f, input logic r);
        @(posedge clk);
        #2;
        req_valid_i = v;
        req_addr_i  = a;
        flush_i     = f;
        reset       = r;
        @(negedge clk);
    endtask

    localparam logic [N*W-1:0] T1234 = {6'd4, 6'd3, 6'd2, 6'd1};

    initial begin
        logic [3:0]   v;
        logic [N*W-1:0] a;
        logic         held_ok;
        reset       = 1'b1;
        req_valid_i = '0;
        req_addr_i  = '0;
        flush_i     = 1'b0;
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // Reset: no ready even with all requests valid.
        cyc(4'b1111, T1234, 1'b0, 1'b0);
        check("rst_ready", 32'(req_ready_o), 32'h0);
        check("rst_fin0", 32'(finish_0_o), 32'h0);
        check("rst_cnt", 32'(conflict_cnt_o), 32'h0);
        cyc(4'b0000, '0, 1'b0, 1'b1);

        // Single alu1 request, tag 5.
        cyc(4'b0001, {18'd0, 6'd5}, 1'b0, 1'b1);
        check("single_ready", 32'(req_ready_o), 32'h1);
        cyc(4'b0100, {6'd0, 6'd3, 6'd0, 6'd0}, 1'b0, 1'b1);
        check("single_fin0", 32'(finish_0_o), 32'h1);
        check("single_addr0", 32'(finish_0_addr_o), 32'd5);
        check("single_fin1", 32'(finish_1_o), 32'h0);
        check("ptr1_ready", 32'(req_ready_o), 32'h4);

        // Pointer now 3: wrap case with units 3 and 0.
        cyc(4'b1001, T1234, 1'b0, 1'b1);
        check("wrap_ready", 32'(req_ready_o), 32'h9);
        check("mul_addr0", 32'(finish_0_addr_o), 32'd3);
        cyc(4'b1000, T1234, 1'b0, 1'b1);
        check("wrap_addr0", 32'(finish_0_addr_o), 32'd4);
        check("wrap_fin1", 32'(finish_1_o), 32'h1);
        check("wrap_addr1", 32'(finish_1_addr_o), 32'd1);
        check("ptr_after_wrap", 32'(req_ready_o), 32'h8);

        // All four valid from pointer 0.
        cyc(4'b1111, T1234, 1'b0, 1'b1);
        check("all_ready_n", 32'(req_ready_o), 32'h3);
        check("all_cnt_n", 32'(conflict_cnt_o), 32'd0);
        cyc(4'b1111, T1234, 1'b0, 1'b1);
        check("all_ready_n1", 32'(req_ready_o), 32'hC);
        check("all_addr0_n", 32'(finish_0_addr_o), 32'd1);
        check("all_addr1_n", 32'(finish_1_addr_o), 32'd2);
        check("all_cnt_n1", 32'(conflict_cnt_o), 32'd1);
        cyc(4'b1111, T1234, 1'b0, 1'b1);
        check("all_ready_n2", 32'(req_ready_o), 32'h3);
        check("all_addr0_n1", 32'(finish_0_addr_o), 32'd3);
        check("all_addr1_n1", 32'(finish_1_addr_o), 32'd4);
        check("all_cnt_n2", 32'(conflict_cnt_o), 32'd2);

        // Flush suppresses grants; following cycle grants both.
        cyc(4'b0110, T1234, 1'b1, 1'b1);
        check("flush_ready", 32'(req_ready_o), 32'h0);
        check("flush_cnt", 32'(conflict_cnt_o), 32'd3);
        cyc(4'b0110, T1234, 1'b0, 1'b1);
        check("flush_fin0", 32'(finish_0_o), 32'h0);
        check("flush_fin1", 32'(finish_1_o), 32'h0);
        check("postflush_ready", 32'(req_ready_o), 32'h6);
        cyc(4'b0011, T1234, 1'b0, 1'b1);
        check("postflush_addr0", 32'(finish_0_addr_o), 32'd3);
        check("postflush_addr1", 32'(finish_1_addr_o), 32'd2);
        check("ptr2_ready", 32'(req_ready_o), 32'h3);

        // Reset right after a two-grant cycle.
        cyc(4'b0000, T1234, 1'b0, 1'b0);
        check("midrst_fin0", 32'(finish_0_o), 32'h0);
        check("midrst_fin1", 32'(finish_1_o), 32'h0);
        check("midrst_addr0", 32'(finish_0_addr_o), 32'h0);
        cyc(4'b0000, T1234, 1'b0, 1'b1);
        cyc(4'b0000, T1234, 1'b0, 1'b1);
        check("postrst_fin0", 32'(finish_0_o), 32'h0);
        check("postrst_fin1", 32'(finish_1_o), 32'h0);

        // Random traffic honouring hold-until-ready.
        v = '0;
        a = '0;
        for (int it = 0; it < 3000; it++) begin
            @(posedge clk);
            #2;
            held_ok = reset;
            for (int k = 0; k < 4; k++) begin
                if (!(held_ok && v[k] && !m_gnt[k])) begin
                    v[k] = 1'($urandom_range(0, 1));
                    a[k*W +: W] = W'($urandom_range(0, 63));
                end
            end
            req_valid_i = v;
            req_addr_i  = a;
            flush_i     = ($urandom_range(0, 9) == 0);
            reset       = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        cyc(4'b0000, '0, 1'b0, 1'b1);

        // Drive the conflict counter up to its saturation point.
        for (int it = 0; it < 70000 && m_cnt < 32'hFFFE; it++) begin
            cyc(4'b1111, T1234, 1'b0, 1'b1);
        end
        check("cnt_preset", 32'(conflict_cnt_o), 32'hFFFE);
        cyc(4'b0111, T1234, 1'b0, 1'b1);
        cyc(4'b1110, T1234, 1'b0, 1'b1);
        cyc(4'b1011, T1234, 1'b0, 1'b1);
        check("cnt_sat", 32'(conflict_cnt_o), 32'hFFFF);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
